// File: rtl/sys_pkg.sv
// sys_pkg: default geometry and counter width shared by the deskew block and its bench
package sys_pkg;
  localparam int DEF_LANES      = 4;
  localparam int DEF_DAT_WIDTH  = 16;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int VEC_CNT_W      = 16;
endpackage

// File: rtl/sys_deskew_if.sv
// sys_deskew_if: skewed lane inputs plus the aligned valid/ready output bus
//   i_lane_vld/i_lane_dat: lane i of a vector arrives i cycles after lane 0
//   o_vld/o_rdy/o_dat: aligned vector handshake, lane i at [i*DAT_WIDTH +: DAT_WIDTH]
interface sys_deskew_if import sys_pkg::*; #(
  parameter int LANES     = DEF_LANES,
  parameter int DAT_WIDTH = DEF_DAT_WIDTH
);
  logic [LANES-1:0]           i_lane_vld;
  logic [DAT_WIDTH-1:0]       i_lane_dat [LANES];
  logic                       o_vld;
  logic                       o_rdy;
  logic [LANES*DAT_WIDTH-1:0] o_dat;
  modport master (output i_lane_vld, i_lane_dat, o_rdy, input o_vld, o_dat);
  modport slave  (input i_lane_vld, i_lane_dat, o_rdy, output o_vld, o_dat);
endinterface

// File: rtl/sys_deskew_fifo.sv
// sys_deskew_fifo: synchronous FIFO, unreset storage, output reads zero while empty
//   wr_en_i/wr_dat_i: push (ignored when full unless popping in the same cycle)
//   rd_en_i/rd_dat_o: pop of the head entry, full_o/empty_o: occupancy flags
module sys_deskew_fifo import sys_pkg::*; #(
  parameter int WIDTH = DEF_LANES * DEF_DAT_WIDTH,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_dat_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_dat_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q, cnt_d;
  logic             wr, rd;
  assign full_o   = cnt_q == (AW+1)'(DEPTH);
  assign empty_o  = cnt_q == '0;
  assign rd       = rd_en_i & ~empty_o;
  assign wr       = wr_en_i & (~full_o | rd);
  assign cnt_d    = cnt_q + {{AW{1'b0}}, wr} - {{AW{1'b0}}, rd};
  assign rd_dat_o = empty_o ? '0 : mem_q[rd_ptr_q];
  always_ff @(posedge clk)
    if (wr) mem_q[wr_ptr_q] <= wr_dat_i;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + AW'(wr);
      rd_ptr_q <= rd_ptr_q + AW'(rd);
      cnt_q    <= cnt_d;
    end
endmodule

// File: rtl/sys_deskew.sv
// sys_deskew: realigns systolically skewed lanes into whole vectors buffered in a FIFO
//   bus: skewed lane inputs in, aligned vector handshake out
//   i_clr_err: clears o_err_align/o_err_ovf (a same-cycle error event keeps its flag)
//   o_err_align: sticky partial vector, o_err_ovf: sticky dropped vector, o_vec_cnt: FIFO writes
module sys_deskew import sys_pkg::*; #(
  parameter int LANES      = DEF_LANES,
  parameter int DAT_WIDTH  = DEF_DAT_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sys_deskew_if.slave          bus,
  input  logic                 i_clr_err,
  output logic                 o_err_align,
  output logic                 o_err_ovf,
  output logic [VEC_CNT_W-1:0] o_vec_cnt
);
  localparam int VW = LANES * DAT_WIDTH;
  logic [LANES-1:0]     dly_vld;
  logic [VW-1:0]        dly_dat;
  logic [LANES-1:0]     align_vld_q;
  logic [VW-1:0]        align_dat_q;
  logic                 err_align_q, err_align_d;
  logic                 err_ovf_q, err_ovf_d;
  logic [VEC_CNT_W-1:0] vec_cnt_q, vec_cnt_d;
  logic                 all_vld, any_vld, full, empty, pop, push;
  logic [VW-1:0]        fifo_dat;
  // Early lanes wait LANES-1-i cycles so every lane of a vector lands in the same cycle
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    localparam int N = LANES - 1 - g;
    if (N == 0) begin : g_pass
      assign dly_vld[g] = bus.i_lane_vld[g];
      assign dly_dat[g*DAT_WIDTH +: DAT_WIDTH] = bus.i_lane_dat[g];
    end else begin : g_dly
      logic [N-1:0]         vld_q;
      logic [DAT_WIDTH-1:0] dat_q [N];
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) vld_q <= '0;
        else vld_q <= N'({vld_q, bus.i_lane_vld[g]});
      always_ff @(posedge clk) begin
        dat_q[0] <= bus.i_lane_dat[g];
        for (int k = 1; k < N; k++) dat_q[k] <= dat_q[k-1];
      end
      assign dly_vld[g] = vld_q[N-1];
      assign dly_dat[g*DAT_WIDTH +: DAT_WIDTH] = dat_q[N-1];
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) align_vld_q <= '0;
    else align_vld_q <= dly_vld;
  always_ff @(posedge clk)
    align_dat_q <= dly_dat;
  // A full FIFO still accepts a vector when its head leaves in the same cycle
  always_comb begin
    all_vld     = &align_vld_q;
    any_vld     = |align_vld_q;
    pop         = ~empty & bus.o_rdy;
    push        = all_vld & (~full | pop);
    err_align_d = (any_vld & ~all_vld) | (err_align_q & ~i_clr_err);
    err_ovf_d   = (all_vld & full & ~pop) | (err_ovf_q & ~i_clr_err);
    vec_cnt_d   = push ? vec_cnt_q + VEC_CNT_W'(1) : vec_cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      err_align_q <= 1'b0;
      err_ovf_q   <= 1'b0;
      vec_cnt_q   <= '0;
    end else begin
      err_align_q <= err_align_d;
      err_ovf_q   <= err_ovf_d;
      vec_cnt_q   <= vec_cnt_d;
    end
  sys_deskew_fifo #(.WIDTH(VW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en_i  (push),
    .wr_dat_i (align_dat_q),
    .rd_en_i  (pop),
    .rd_dat_o (fifo_dat),
    .full_o   (full),
    .empty_o  (empty)
  );
  assign bus.o_vld   = ~empty;
  assign bus.o_dat   = fifo_dat;
  assign o_err_align = err_align_q;
  assign o_err_ovf   = err_ovf_q;
  assign o_vec_cnt   = vec_cnt_q;
endmodule

// File: tb/tb_sys_deskew.sv
// tb_sys_deskew: randomized bench against a vector-level model of the deskew block
module tb_sys_deskew;
  import sys_pkg::*;
  localparam int L = 4;
  localparam int W = 16;
  localparam int D = 4;
  localparam int N = 1024;
  localparam int TW = 1 + L*W + 2 + 16;
  logic clk = 0;
  logic rst_n = 1;
  logic clr = 0;
  logic err_align, err_ovf;
  logic [15:0] vec_cnt;
  always #5 clk = ~clk;
  sys_deskew_if #(.LANES(L), .DAT_WIDTH(W)) bus();
  sys_deskew #(.LANES(L), .DAT_WIDTH(W), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .i_clr_err(clr),
    .o_err_align(err_align), .o_err_ovf(err_ovf), .o_vec_cnt(vec_cnt)
  );
  // Vectors are described by their lane-0 start cycle: lane i of vector s is driven in cycle s+i
  logic [L-1:0]   mask [N];
  logic [L*W-1:0] vdat [N];
  logic [L*W-1:0] mq [$];
  logic m_ea = 0, m_eo = 0;
  logic [15:0] m_cnt = 0;
  int cyc = 0, n_cmp = 0, n_bad = 0;

  function automatic logic [TW-1:0] exp_t();
    logic [L*W-1:0] d = '0;
    if (mq.size() > 0) d = mq[0];
    return {mq.size() > 0, d, m_ea, m_eo, m_cnt};
  endfunction

  function automatic logic [TW-1:0] dut_t();
    return {bus.o_vld, bus.o_dat, err_align, err_ovf, vec_cnt};
  endfunction

  task automatic vec(input int s, input logic [L-1:0] m, input logic [L*W-1:0] d);
    mask[s] = m;
    vdat[s] = d;
  endtask

  task automatic rnd_vec(input int s, input logic [L-1:0] m);
    vec(s, m, {$urandom, $urandom});
  endtask

  // One clock: drive the lanes for cycle cyc, let the edge happen, advance the model, settle at negedge
  task automatic tick();
    int s;
    logic all, any, pop, full, push;
    for (int i = 0; i < L; i++) begin
      s = cyc - i;
      bus.i_lane_vld[i] = (s >= 0) && mask[s][i];
      bus.i_lane_dat[i] = bus.i_lane_vld[i] ? vdat[s][i*W +: W] : W'($urandom);
    end
    @(posedge clk);
    s = cyc - L;
    all = (s >= 0) && (&mask[s]);
    any = (s >= 0) && (|mask[s]);
    pop = mq.size() > 0 && bus.o_rdy;
    full = mq.size() == D;
    push = all && (!full || pop);
    m_ea = (any && !all) || (m_ea && !clr);
    m_eo = (all && full && !pop) || (m_eo && !clr);
    if (pop) void'(mq.pop_front());
    if (push) begin
      mq.push_back(vdat[s]);
      m_cnt++;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic model_reset();
    mq.delete();
    m_ea = 0;
    m_eo = 0;
    m_cnt = 0;
    for (int i = 0; i < N; i++) mask[i] = '0;
    bus.i_lane_vld = '0;
  endtask

  task automatic test_reset();
    bus.i_lane_vld = '0;
    bus.o_rdy = 0;
    for (int i = 0; i < L; i++) bus.i_lane_dat[i] = '0;
    for (int i = 0; i < N; i++) begin
      mask[i] = '0;
      vdat[i] = '0;
    end
    #1 rst_n = 0;
    #1;
    n_cmp++; if (bus.o_vld !== 1'b0) begin n_bad++; $display("FAIL reset_vld got=%b exp=0", bus.o_vld); end
    n_cmp++; if (bus.o_dat !== '0) begin n_bad++; $display("FAIL reset_dat got=%h exp=0", bus.o_dat); end
    n_cmp++; if (vec_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_cnt got=%0d exp=0", vec_cnt); end
    n_cmp++; if ({err_align, err_ovf} !== 2'b00) begin n_bad++; $display("FAIL reset_err got=%b exp=00", {err_align, err_ovf}); end
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (3) begin
      tick();
      n_cmp++; if (dut_t() !== exp_t()) begin n_bad++; $display("FAIL reset_idle cyc=%0d got=%h exp=%h", cyc, dut_t(), exp_t()); end
    end
  endtask

  task automatic test_single();
    int s = cyc + 1, first = -1;
    vec(s, '1, 64'h1003_1002_1001_1000);
    bus.o_rdy = 1;
    while (cyc < s + L + 4) begin
      tick();
      n_cmp++; if (dut_t() !== exp_t()) begin n_bad++; $display("FAIL single cyc=%0d got=%h exp=%h", cyc, dut_t(), exp_t()); end
      if (bus.o_vld && first < 0) begin
        first = cyc;
        n_cmp++; if (bus.o_dat !== 64'h1003_1002_1001_1000) begin n_bad++; $display("FAIL single_dat got=%h exp=1003100210011000", bus.o_dat); end
      end
    end
    n_cmp++; if (first != s + L + 1) begin n_bad++; $display("FAIL single_latency got=%0d exp=%0d", first - s, L + 1); end
    n_cmp++; if (vec_cnt !== 16'd1) begin n_bad++; $display("FAIL single_cnt got=%0d exp=1", vec_cnt); end
  endtask

  task automatic test_back_to_back();
    int s0 = cyc + 1, run = 0, best = 0, seen = 0;
    logic [15:0] c0 = vec_cnt;
    for (int k = 0; k < 8; k++) rnd_vec(s0 + k, '1);
    bus.o_rdy = 1;
    while (cyc < s0 + L + 12) begin
      tick();
      n_cmp++; if (dut_t() !== exp_t()) begin n_bad++; $display("FAIL b2b cyc=%0d got=%h exp=%h", cyc, dut_t(), exp_t()); end
      run = bus.o_vld ? run + 1 : 0;
      seen += bus.o_vld ? 1 : 0;
      if (run > best) best = run;
    end
    n_cmp++; if (best != 8 || seen != 8) begin n_bad++; $display("FAIL b2b_throughput got=%0d/%0d exp=8/8", best, seen); end
    n_cmp++; if (vec_cnt - c0 !== 16'd8) begin n_bad++; $display("FAIL b2b_cnt got=%0d exp=8", vec_cnt - c0); end
    n_cmp++; if ({err_align, err_ovf} !== 2'b00) begin n_bad++; $display("FAIL b2b_err got=%b exp=00", {err_align, err_ovf}); end
  endtask

  task automatic test_overflow();
    int s0 = cyc + 1;
    logic [15:0] c0 = vec_cnt;
    logic [L*W-1:0] got [$];
    for (int k = 0; k < 6; k++) rnd_vec(s0 + k, '1);
    bus.o_rdy = 0;
    while (cyc <= s0 + L + 6) begin
      tick();
      n_cmp++; if (dut_t() !== exp_t()) begin n_bad++; $display("FAIL ovf_fill cyc=%0d got=%h exp=%h", cyc, dut_t(), exp_t()); end
    end
    n_cmp++; if (err_ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_flag got=%b exp=1", err_ovf); end
    n_cmp++; if (vec_cnt - c0 !== 16'd4) begin n_bad++; $display("FAIL ovf_cnt got=%0d exp=4", vec_cnt - c0); end
    bus.o_rdy = 1;
    repeat (6) begin
      if (bus.o_vld) got.push_back(bus.o_dat);
      tick();
      n_cmp++; if (dut_t() !== exp_t()) begin n_bad++; $display("FAIL ovf_drain cyc=%0d got=%h exp=%h", cyc, dut_t(), exp_t()); end
    end
    n_cmp++; if (got.size() != 4) begin n_bad++; $display("FAIL ovf_drain_n got=%0d exp=4", got.size()); end
    for (int k = 0; k < 4 && k < got.size(); k++) begin
      n_cmp++; if (got[k] !== vdat[s0 + k]) begin n_bad++; $display("FAIL ovf_order k=%0d got=%h exp=%h", k, got[k], vdat[s0 + k]); end
    end
    clr = 1;
    tick();
    clr = 0;
    n_cmp++; if (err_ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_clr got=%b exp=0", err_ovf); end
  endtask

  task automatic test_align();
    int s = cyc + 1;
    rnd_vec(s, 4'b1011);
    bus.o_rdy = 1;
    while (cyc <= s + L + 2) begin
      tick();
      n_cmp++; if (dut_t() !== exp_t()) begin n_bad++; $display("FAIL align cyc=%0d got=%h exp=%h", cyc, dut_t(), exp_t()); end
      n_cmp++; if (bus.o_vld !== 1'b0) begin n_bad++; $display("FAIL align_noout cyc=%0d got=%b exp=0", cyc, bus.o_vld); end
    end
    n_cmp++; if (err_align !== 1'b1) begin n_bad++; $display("FAIL align_flag got=%b exp=1", err_align); end
    clr = 1;
    tick();
    clr = 0;
    n_cmp++; if (err_align !== 1'b0) begin n_bad++; $display("FAIL align_clr got=%b exp=0", err_align); end
    s = cyc + 1;
    rnd_vec(s, 4'b0111);
    while (cyc <= s + L + 1) begin
      clr = cyc == s + L;
      tick();
      clr = 0;
    end
    n_cmp++; if (err_align !== 1'b1) begin n_bad++; $display("FAIL align_evt_wins got=%b exp=1", err_align); end
    clr = 1;
    tick();
    clr = 0;
    n_cmp++; if (dut_t() !== exp_t()) begin n_bad++; $display("FAIL align_end cyc=%0d got=%h exp=%h", cyc, dut_t(), exp_t()); end
  endtask

  task automatic test_full_stream();
    int s0 = cyc + 1;
    for (int k = 0; k < 14; k++) rnd_vec(s0 + k, '1);
    while (cyc < s0 + L + 20) begin
      bus.o_rdy = cyc >= s0 + L + 4;
      tick();
      n_cmp++; if (dut_t() !== exp_t()) begin n_bad++; $display("FAIL full cyc=%0d got=%h exp=%h", cyc, dut_t(), exp_t()); end
      if (cyc >= s0 + L + 4 && cyc <= s0 + L + 14) begin
        n_cmp++; if (bus.o_vld !== 1'b1) begin n_bad++; $display("FAIL full_vld cyc=%0d got=%b exp=1", cyc, bus.o_vld); end
      end
    end
    n_cmp++; if (err_ovf !== 1'b0) begin n_bad++; $display("FAIL full_noovf got=%b exp=0", err_ovf); end
  endtask

  task automatic test_reset_mid();
    int s0 = cyc + 1, first = -1, s;
    for (int k = 0; k < 5; k++) rnd_vec(s0 + k, '1);
    bus.o_rdy = 0;
    while (cyc < s0 + L + 3) tick();
    n_cmp++; if (dut_t() !== exp_t()) begin n_bad++; $display("FAIL mid_pre cyc=%0d got=%h exp=%h", cyc, dut_t(), exp_t()); end
    rst_n = 0;
    model_reset();
    #1;
    n_cmp++; if ({bus.o_vld, vec_cnt} !== 17'd0) begin n_bad++; $display("FAIL mid_rst got=%h exp=0", {bus.o_vld, vec_cnt}); end
    n_cmp++; if (bus.o_dat !== '0) begin n_bad++; $display("FAIL mid_rst_dat got=%h exp=0", bus.o_dat); end
    repeat (2) @(negedge clk);
    rst_n = 1;
    bus.o_rdy = 1;
    repeat (12) begin
      tick();
      n_cmp++; if (bus.o_vld !== 1'b0 || dut_t() !== exp_t()) begin n_bad++; $display("FAIL mid_stale cyc=%0d got=%h exp=%h", cyc, dut_t(), exp_t()); end
    end
    s = cyc + 1;
    rnd_vec(s, '1);
    while (cyc < s + L + 3) begin
      tick();
      if (bus.o_vld && first < 0) first = cyc;
    end
    n_cmp++; if (first != s + L + 1) begin n_bad++; $display("FAIL mid_latency got=%0d exp=%0d", first - s, L + 1); end
    n_cmp++; if (vec_cnt !== 16'd1) begin n_bad++; $display("FAIL mid_cnt got=%0d exp=1", vec_cnt); end
  endtask

  task automatic test_random();
    int s0 = cyc + 1;
    for (int s = s0; s < s0 + 250; s++)
      rnd_vec(s, ($urandom % 8 == 0) ? L'($urandom) : (($urandom % 3 == 0) ? '0 : '1));
    while (cyc < s0 + 250 + L + 8) begin
      bus.o_rdy = ($urandom % 4) != 0;
      clr = ($urandom % 20) == 0;
      tick();
      clr = 0;
      n_cmp++; if (dut_t() !== exp_t()) begin n_bad++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, dut_t(), exp_t()); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_align();
    test_full_stream();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
